// File: rtl/camera_i2c_target.sv
// I2C target serving a small byte register file, used as a camera-sensor stand-in.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
`timescale 1ns/1ps
module camera_i2c_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h5D,
    parameter int         REG_AW    = 4,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic [REG_AW-1:0] address,
    output logic [7:0]        readdata,
    output logic              busy
);

    localparam int NREG = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] PTR_ONE = 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_ADDR_ACK = 4'd2;
    localparam logic [3:0] S_REG      = 4'd3;
    localparam logic [3:0] S_REG_ACK  = 4'd4;
    localparam logic [3:0] S_WR_DATA  = 4'd5;
    localparam logic [3:0] S_WR_ACK   = 4'd6;
    localparam logic [3:0] S_RD_DATA  = 4'd7;
    localparam logic [3:0] S_RD_ACK   = 4'd8;
    localparam logic [3:0] S_HOLD     = 4'd9;

    // Bits [1:0] form the synchroniser, bit [2] is the history used for edge detection.
    logic [2:0] scl_sync, sda_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every FF samples pre-edge values.
            scl_sync <= {scl_sync[1:0], scl_in};
            sda_sync <= {sda_sync[1:0], sda_in};
        end
    end

    logic scl, scl_prev, sda, sda_prev;
    assign scl      = scl_sync[1];
    assign scl_prev = scl_sync[2];
    assign sda      = sda_sync[1];
    assign sda_prev = sda_sync[2];

    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_rise   = scl & ~scl_prev;
    assign scl_fall   = ~scl & scl_prev;
    assign start_cond = scl & scl_prev & sda_prev & ~sda;
    assign stop_cond  = scl & scl_prev & ~sda_prev & sda;

    logic [3:0]        state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              rw;
    logic              ack_phase;
    logic [REG_AW-1:0] pointer;
    logic [7:0]        regs [NREG];

    logic [7:0] rx_byte, ptr_byte;
    assign rx_byte  = {shreg[6:0], sda};
    assign ptr_byte = regs[pointer];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            pointer   <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            readdata  <= 8'h00;
            // NOTE: the register file is small and must come up at RESET_VAL, so it sits in the reset branch.
            for (int i = 0; i < NREG; i++) regs[i] <= RESET_VAL;
        end else begin
            readdata <= regs[address];
            if (start_cond) begin
                state     <= S_ADDR;
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (stop_cond) begin
                state     <= S_IDLE;
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_REG, S_WR_DATA: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (state == S_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    busy  <= 1'b1;
                                    rw    <= rx_byte[0];
                                    state <= S_ADDR_ACK;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= S_IDLE;
                                end
                            end else if (state == S_REG) begin
                                pointer <= rx_byte[REG_AW-1:0];
                                state   <= S_REG_ACK;
                            end else begin
                                regs[pointer] <= rx_byte;
                                pointer       <= pointer + PTR_ONE;
                                state         <= S_WR_ACK;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // First falling edge pulls ACK low, the next one releases it and moves on.
                    S_ADDR_ACK, S_REG_ACK, S_WR_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase <= 1'b1;
                            sda_oe    <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            sda_oe    <= 1'b0;
                            if (state == S_ADDR_ACK && rw) begin
                                shreg   <= ptr_byte;
                                sda_oe  <= ~ptr_byte[7];
                                bit_cnt <= 4'd0;
                                state   <= S_RD_DATA;
                            end else if (state == S_ADDR_ACK) begin
                                state <= S_REG;
                            end else begin
                                state <= S_WR_DATA;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b0;
                                state   <= S_RD_ACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                pointer   <= pointer + PTR_ONE;
                                ack_phase <= 1'b1;
                            end else begin
                                state <= S_HOLD;
                            end
                        end else if (scl_fall && ack_phase) begin
                            ack_phase <= 1'b0;
                            shreg     <= ptr_byte;
                            sda_oe    <= ~ptr_byte[7];
                            bit_cnt   <= 4'd0;
                            state     <= S_RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_i2c_target.sv
// Directed bench for camera_i2c_target: a bit-banged master on a wired-AND SDA line.
`timescale 1ns/1ps
module tb_camera_i2c_target;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [3:0] address = 4'd0;
    logic [7:0] readdata;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    camera_i2c_target #(.DEV_ADDR(7'h5D), .REG_AW(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_in), .sda_oe(sda_oe),
        .address(address), .readdata(readdata), .busy(busy)
    );

    task automatic i2c_start();
        sda_m = 1'b1; #T; scl = 1'b1; #T; sda_m = 1'b0; #T; scl = 1'b0; #T;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #T; scl = 1'b1; #T; sda_m = 1'b1; #T;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #T; scl = 1'b1; #T; scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #T; scl = 1'b1; #(T/2); ack = sda_in; #(T/2); scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #T; scl = 1'b1; #(T/2); d[i] = sda_in; #(T/2); scl = 1'b0;
        end
        sda_m = nack; #T; scl = 1'b1; #T; scl = 1'b0; #T; sda_m = 1'b1;
    endtask

    task automatic read_reg(input logic [3:0] idx, output logic [7:0] d);
        @(negedge clk); address = idx;
        @(negedge clk); d = readdata;
    endtask

    task automatic test_reset();
        #20;
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (readdata !== 8'h00) begin n_fail++; $display("FAIL reset_readdata: got %h want 00", readdata); end
        @(negedge clk); reset = 1'b0; #T;
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hBA, a0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b want 1", busy); end
        write_byte(8'h03, a1);
        write_byte(8'h5A, a2);
        i2c_stop();
        n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL write_acks: got %b want 000", {a0, a1, a2}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_stop: got %b want 0", busy); end
        read_reg(4'd3, d);
        n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL write_reg3: got %h want 5a", d); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hBA, a0); write_byte(8'h0F, a1);
        write_byte(8'h11, a2); write_byte(8'h22, a3);
        i2c_stop();
        n_checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); end
        read_reg(4'd15, d);
        n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL wrap_reg15: got %h want 11", d); end
        read_reg(4'd0, d);
        n_checks++; if (d !== 8'h22) begin n_fail++; $display("FAIL wrap_reg0: got %h want 22", d); end
    endtask

    task automatic test_read();
        logic a;
        logic [7:0] d0, d1;
        i2c_start();
        write_byte(8'hBA, a); write_byte(8'h02, a); write_byte(8'hC3, a); write_byte(8'h3C, a);
        i2c_stop();
        i2c_start();
        write_byte(8'hBA, a); write_byte(8'h02, a);
        i2c_start();
        write_byte(8'hBB, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack: got %b want 0", a); end
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        n_checks++; if (d0 !== 8'hC3) begin n_fail++; $display("FAIL read_byte0: got %h want c3", d0); end
        n_checks++; if (d1 !== 8'h3C) begin n_fail++; $display("FAIL read_byte1: got %h want 3c", d1); end
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_nack_release: got %b want 0", sda_oe); end
        i2c_stop();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_stop: got %b want 0", busy); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1, a2;
        logic oe_seen;
        logic [7:0] d;
        oe_seen = 1'b0;
        fork
            begin : watch
                forever begin @(posedge clk); if (sda_oe) oe_seen = 1'b1; end
            end
            begin
                i2c_start();
                write_byte(8'hA4, a0);
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_busy: got %b want 0", busy); end
                write_byte(8'h03, a1); write_byte(8'h77, a2);
                i2c_stop();
                disable watch;
            end
        join
        n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL wrong_no_ack: got %b want 111", {a0, a1, a2}); end
        n_checks++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL wrong_sda_driven: got %b want 0", oe_seen); end
        read_reg(4'd3, d);
        n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL wrong_reg3: got %h want 3c", d); end
    endtask

    task automatic test_mid_start();
        logic a, a_re, a_data;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hBA, a); write_byte(8'h05, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        write_byte(8'hBA, a_re);
        write_byte(8'h06, a);
        write_byte(8'h99, a_data);
        n_checks++; if ({a_re, a_data} !== 2'b00) begin n_fail++; $display("FAIL mid_restart_acks: got %b want 00", {a_re, a_data}); end
        i2c_stop();
        read_reg(4'd5, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL mid_reg5: got %h want 00", d); end
        read_reg(4'd6, d);
        n_checks++; if (d !== 8'h99) begin n_fail++; $display("FAIL mid_reg6: got %h want 99", d); end
    endtask

    task automatic test_reset_mid();
        logic a;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hBA, a); write_byte(8'h00, a);
        i2c_start();
        write_byte(8'hBB, a);
        #T;
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_drive: got %b want 1", sda_oe); end
        reset = 1'b1;
        #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_async_oe: got %b want 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk); @(negedge clk); reset = 1'b0;
        read_reg(4'd0, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_reg0: got %h want 00", d); end
        read_reg(4'd6, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_reg6: got %h want 00", d); end
        i2c_stop();
        i2c_start();
        write_byte(8'hBA, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL rst_recover_ack: got %b want 0", a); end
        i2c_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrap();
        test_read();
        test_wrong_addr();
        test_mid_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
